// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: runs one register-to-register micro-op at a time against a
// 2R/1W register file (read, ALU step, write-back, done pulse).
// Ports: clk, rst_n (async, active low); op_valid/op_ready handshake with
// op_code, op_rd, op_rs1, op_rs2, op_imm; register file lines rf_mode
// (0 read / 1 write), rf_waddr, rf_wdata, rf_raddr1/2, rf_rdata1/2
// (combinational); retire outputs done (pulse), result, carry (held).
// Optional macro ZERO_REG_EN: register 0 reads as zero and is never written.
module rf_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_code,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic [DATA_W-1:0] op_imm,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [1:0]        state;
    logic [2:0]        code_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              pend_carry;

    logic [DATA_W:0]   alu;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic              wr_ok_q;
    logic              wr_ok_ldi;

    // Hardwired-zero register: operand forced to 0, write suppressed.
    assign opnd1 = (ZERO_REG && rf_raddr1 == '0) ? '0 : rf_rdata1;
    assign opnd2 = (ZERO_REG && rf_raddr2 == '0) ? '0 : rf_rdata2;
    assign wr_ok_q   = !(ZERO_REG && rd_q == '0);
    assign wr_ok_ldi = !(ZERO_REG && op_rd == '0);

    // Extra top bit carries ADD carry-out, and SUB borrow (set when a < b).
    always_comb begin
        alu = '0;
        unique case (code_q)
            OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu = {1'b0, a_q & b_q};
            OP_OR:   alu = {1'b0, a_q | b_q};
            OP_XOR:  alu = {1'b0, a_q ^ b_q};
            OP_MOV:  alu = {1'b0, a_q};
            OP_LDI:  alu = '0;
            OP_NOP:  alu = '0;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_ready   <= 1'b1;
            rf_mode    <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_raddr1  <= '0;
            rf_raddr2  <= '0;
            done       <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            code_q     <= '0;
            rd_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pend_carry <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        code_q   <= op_code;
                        rd_q     <= op_rd;
                        op_ready <= 1'b0;
                        if (op_code == OP_LDI) begin
                            // LDI needs no operands: straight to write-back.
                            state      <= S_WRITE;
                            rf_mode    <= wr_ok_ldi;
                            rf_waddr   <= op_rd;
                            rf_wdata   <= op_imm;
                            pend_carry <= 1'b0;
                        end else begin
                            state     <= S_READ;
                            rf_raddr1 <= op_rs1;
                            rf_raddr2 <= op_rs2;
                        end
                    end
                end
                S_READ: begin
                    a_q   <= opnd1;
                    b_q   <= opnd2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (code_q == OP_NOP) begin
                        state    <= S_IDLE;
                        op_ready <= 1'b1;
                        done     <= 1'b1;
                        result   <= '0;
                        carry    <= 1'b0;
                    end else begin
                        state      <= S_WRITE;
                        rf_mode    <= wr_ok_q;
                        rf_waddr   <= rd_q;
                        rf_wdata   <= alu[DATA_W-1:0];
                        pend_carry <= alu[DATA_W];
                    end
                end
                S_WRITE: begin
                    state    <= S_IDLE;
                    rf_mode  <= 1'b0;
                    op_ready <= 1'b1;
                    done     <= 1'b1;
                    result   <= rf_wdata;
                    carry    <= pend_carry;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rf_op_sequencer.md
Name:
rf_op_sequencer

Overview:
Sequencer that owns the 32-entry x 16-bit two-read/one-write register file port and executes one register-to-register micro-op at a time. It accepts an op over a valid/ready handshake and drives the file's mode, address and write-data lines. It performs the read, the ALU step and the write-back, then pulses done with the result and carry. It sits between an instruction source (bench or future decoder) and the register file.

Parameters:
DATA_W, 16, register width; data ports, result and ALU use it.
ADDR_W, 5, register address width (32 entries).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
op_valid  input  1  op present on op_* lines.
op_ready  output  1  sequencer can accept an op.
op_code  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV (rd=rs1), 110 LDI (rd=imm), 111 NOP.
op_rd  input  ADDR_W  destination register.
op_rs1  input  ADDR_W  source 1.
op_rs2  input  ADDR_W  source 2.
op_imm  input  DATA_W  immediate for LDI.
rf_mode  output  1  0 = read, 1 = write; to register file mode.
rf_waddr  output  ADDR_W  register file write address.
rf_wdata  output  DATA_W  register file write value.
rf_raddr1  output  ADDR_W  register file read address 1.
rf_raddr2  output  ADDR_W  register file read address 2.
rf_rdata1  input  DATA_W  register file read value 1 (combinational).
rf_rdata2  input  DATA_W  register file read value 2 (combinational).
done  output  1  one-cycle pulse when an op retires.
result  output  DATA_W  value written (NOP: 0); held until next done.
carry  output  1  ADD carry-out / SUB borrow, else 0; held with result.

Behaviour:
- All outputs registered. Reset values: op_ready=1, rf_mode=0, all addresses, rf_wdata, result and carry = 0, done=0, FSM = IDLE.
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: op_ready=1. When op_valid=1, latch all op fields at the clock edge.
  - op_code 110 (LDI): go to WRITE.
  - All other codes: go to READ.
- READ: op_ready=0, rf_mode=0, rf_raddr1=rs1, rf_raddr2=rs2. Sample rf_rdata1/2 into operand registers at the end of the cycle; go to EXEC.
- EXEC: compute a DATA_W+1 result.
  - ADD: a+b, with carry = bit 16.
  - SUB: a-b, with carry = 1 when a<b (unsigned).
  - AND/OR/XOR: bitwise, carry=0.
  - MOV: a, carry=0.
  - NOP: go to IDLE with done=1, result=0, carry=0, no write.
  - All other codes: go to WRITE.
- WRITE: rf_mode=1 for exactly one cycle, with rf_waddr=rd and rf_wdata=value stable for that whole cycle; go to IDLE. The next cycle has done=1, rf_mode=0, and result/carry updated.
- Latency, counted from the accept edge to the done cycle:
  - ALU ops: 4 cycles (READ, EXEC, WRITE, done).
  - LDI: 2 cycles.
  - NOP: 3 cycles.
- Back-to-back: an op presented while done=1 is accepted (state is IDLE). op_valid is ignored while op_ready=0, and op fields may change freely then.
- Hazard: the write completes before the next READ, so a dependent op (rs = previous rd) reads the new value. No forwarding is needed.
- rs1=rs2 is legal. rd equal to a source is legal; the old value is used as the operand.
- Reset asserted mid-op: all outputs and FSM go to reset values immediately. A WRITE in progress is cut short (rf_mode drops to 0), no done pulse is produced, and the latched op is discarded.

Optional Feature:
ZERO_REG_EN
- Defined: register 0 reads as zero.
  - READ substitutes 0 for an operand whose address is 0, regardless of rf_rdata.
  - Ops with rd=0 skip WRITE (rf_mode stays 0) but still pulse done with the computed result/carry.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then LDI r0=0x1232, LDI r1=0x1263 -> rf_mode high one cycle each with waddr 0/1; done 2 cycles after each accept; result 0x1232, then 0x1263.
- ADD r2=r0+r1 -> reads addr 0/1; writes 0x2495 to r2; carry=0; done 4 cycles after accept; op_ready low for 3 cycles.
- LDI r3=0xA06B, ADD r4=r3+r3 -> result 0x40D6, carry=1. SUB r5=r0-r1 -> 0xFFCF, carry=1.
- Dependent op accepted in the done cycle: XOR r6=r2^r2 -> result 0x0000 read from the updated r2; NOP -> done after 3 cycles, rf_mode never 1.
- Assert rst_n=0 during WRITE of ADD r7 -> rf_mode drops to 0 immediately, no done; after release op_ready=1; a MOV r8=r7 returns r7's pre-op value.
- With ZERO_REG_EN: LDI r0=0x1234 -> no write, done with result 0x1234; ADD r9=r0+r1 -> 0x1263.
